// File: rtl/trace_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_step_sequencer_pkg
// Description : Shared constants and types for the tiny86 trace step
//               sequencer. These cover the step and register-file geometry,
//               the register index map and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_step_sequencer_pkg;

    // Step geometry: [559:464] instr, [463:144] regs, [143:0] two 72-bit hint fields
    localparam int STEP_W       = 560;
    localparam int REGS_W       = 320;
    localparam int STEP_REGS_HI = 463;
    localparam int STEP_REGS_LO = 144;
    localparam int REG_W        = 32;
    localparam int NUM_REGS     = 10;

    // Register index within a 320-bit register file (bit i of CHECK_MASK,
    // field at [i*32 +: 32]); eax is the most significant field.
    localparam int REG_EFLAGS = 0;
    localparam int REG_EIP    = 1;
    localparam int REG_EBP    = 2;
    localparam int REG_ESP    = 3;
    localparam int REG_EDI    = 4;
    localparam int REG_ESI    = 5;
    localparam int REG_EDX    = 6;
    localparam int REG_ECX    = 7;
    localparam int REG_EBX    = 8;
    localparam int REG_EAX    = 9;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

endpackage : trace_step_sequencer_pkg
`default_nettype wire

// File: rtl/trace_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_step_sequencer_if
// Description : Bundles the streamed trace input handshake and the
//               step/exec_regs exchange with tiny86.
//               master : trace source + tiny86 side (drives beats, exec_regs)
//               slave  : sequencer side (drives in_ready, step, step_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_step_sequencer_if #(
    parameter int IN_W = 16
);
    import trace_step_sequencer_pkg::*;

    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [STEP_W-1:0] step;
    logic              step_valid;
    logic [REGS_W-1:0] exec_regs;

    modport master (
        output in_data, in_valid, in_last, exec_regs,
        input  in_ready, step, step_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, exec_regs,
        output in_ready, step, step_valid
    );

endinterface : trace_step_sequencer_if
`default_nettype wire

// File: rtl/trace_step_sequencer_regs_chain_cmp.sv
`default_nettype none
// ============================================================================
// Module      : regs_chain_cmp
// Description : Combinational register-chain continuity compare. Flags a
//               mismatch when any register enabled in CHECK_MASK differs
//               between the previous step's outputs and the current step's
//               inputs.
//   prev_regs in  320  output register file of the previous step
//   cur_regs  in  320  input register file of the current step
//   mismatch  out 1    any enabled register differs
// Revision    : 1.0 - initial release
// ============================================================================
module regs_chain_cmp
    import trace_step_sequencer_pkg::*;
#(
    parameter logic [NUM_REGS-1:0] CHECK_MASK = 10'h3FF
) (
    input  logic [REGS_W-1:0] prev_regs,
    input  logic [REGS_W-1:0] cur_regs,
    output logic              mismatch
);

    logic [NUM_REGS-1:0] w_diff;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_diff[gi] = CHECK_MASK[gi] &&
                                (prev_regs[gi*REG_W +: REG_W] != cur_regs[gi*REG_W +: REG_W]);
        end
    endgenerate

    assign mismatch = |w_diff;

endmodule : regs_chain_cmp
`default_nettype wire

// File: rtl/trace_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trace_step_sequencer
// Description : Upstream feeder for tiny86. Deserialises a narrow trace
//               stream into 560-bit steps, presents each step for one cycle,
//               captures tiny86's output registers and checks that each
//               step's input registers continue the previous step's outputs.
//   clk         in   1    clock
//   rst_n       in   1    asynchronous active-low reset
//   bus         slave     in_data/in_valid/in_last/in_ready,
//                         step/step_valid/exec_regs
//   step_count  out  32   steps presented since reset
//   chain_err   out  1    sticky continuity mismatch
//   err_step    out  32   index of first mismatching step
//   frame_err   out  1    sticky: in_last on a non-final beat
//   done        out  1    trace finished; held until reset
// Revision    : 1.0 - initial release
// ============================================================================
module trace_step_sequencer
    import trace_step_sequencer_pkg::*;
#(
    parameter int                  IN_W       = 16,
    parameter logic [NUM_REGS-1:0] CHECK_MASK = 10'h3FF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    trace_step_sequencer_if.slave        bus,
    output logic [31:0]                  step_count,
    output logic                         chain_err,
    output logic [31:0]                  err_step,
    output logic                         frame_err,
    output logic                         done
);

    localparam int                c_beats     = STEP_W / IN_W;
    localparam int                c_cnt_w     = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

    seq_state_t          r_state;
    logic [c_cnt_w-1:0]  r_beat_cnt;
    logic [STEP_W-1:0]   r_step;
    logic                r_step_valid;
    logic                r_in_ready;
    logic [31:0]         r_step_count;
    logic                r_chain_err;
    logic [31:0]         r_err_step;
    logic                r_frame_err;
    logic                r_done;
    logic                r_have_prev;
    logic [REGS_W-1:0]   r_prev_regs;
    logic                r_last_seen;

    logic                w_accept;
    logic                w_mismatch;

    assign w_accept = bus.in_valid && r_in_ready;

    regs_chain_cmp #(
        .CHECK_MASK (CHECK_MASK)
    ) u_regs_chain_cmp (
        .prev_regs (r_prev_regs),
        .cur_regs  (r_step[STEP_REGS_HI:STEP_REGS_LO]),
        .mismatch  (w_mismatch)
    );

    // in_ready, step_valid and done are registered alongside the state so
    // they always equal the decode of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FILL;
            r_beat_cnt   <= '0;
            r_step       <= '0;
            r_step_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_step_count <= 32'd0;
            r_chain_err  <= 1'b0;
            r_err_step   <= 32'd0;
            r_frame_err  <= 1'b0;
            r_done       <= 1'b0;
            r_have_prev  <= 1'b0;
            r_prev_regs  <= '0;
            r_last_seen  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        // First beat ends up in the top bits after BEATS shifts
                        r_step <= {r_step[STEP_W-IN_W-1:0], bus.in_data};
                        if (r_beat_cnt == c_last_beat) begin
                            r_beat_cnt   <= '0;
                            r_last_seen  <= bus.in_last;
                            r_state      <= S_EXEC;
                            r_in_ready   <= 1'b0;
                            r_step_valid <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            if (bus.in_last) begin
                                // Trace ended mid-step: abandon the partial step
                                r_frame_err <= 1'b1;
                                r_done      <= 1'b1;
                                r_in_ready  <= 1'b0;
                                r_state     <= S_DONE;
                            end
                        end
                    end
                end

                S_EXEC: begin
                    r_step_valid <= 1'b0;
                    if (r_have_prev && w_mismatch && !r_chain_err) begin
                        r_chain_err <= 1'b1;
                        r_err_step  <= r_step_count;
                    end
                    r_prev_regs  <= bus.exec_regs;
                    r_have_prev  <= 1'b1;
                    r_step_count <= r_step_count + 32'd1;
                    if (r_last_seen) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_FILL;
                    end
                end

                S_DONE: begin
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.step       = r_step;
    assign bus.step_valid = r_step_valid;
    assign step_count     = r_step_count;
    assign chain_err      = r_chain_err;
    assign err_step       = r_err_step;
    assign frame_err      = r_frame_err;
    assign done           = r_done;

endmodule : trace_step_sequencer
`default_nettype wire

// File: tb/tb_trace_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_step_sequencer
// Description : Self-checking bench. Two sequencers (full mask and
//               eflags-excluded mask) receive the same randomised traces; a
//               trace-level model predicts presented steps, counts and
//               continuity/framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_step_sequencer;
    import trace_step_sequencer_pkg::*;

    localparam int IN_W  = 16;
    localparam int BEATS = STEP_W / IN_W;

    logic clk;
    logic rst_n;

    trace_step_sequencer_if #(.IN_W(IN_W)) if_a ();
    trace_step_sequencer_if #(.IN_W(IN_W)) if_b ();

    logic [31:0] cnt_a, estep_a, cnt_b, estep_b;
    logic        cerr_a, ferr_a, done_a, cerr_b, ferr_b, done_b;

    trace_step_sequencer #(.IN_W(IN_W), .CHECK_MASK(10'h3FF)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a),
        .step_count(cnt_a), .chain_err(cerr_a), .err_step(estep_a),
        .frame_err(ferr_a), .done(done_a)
    );

    trace_step_sequencer #(.IN_W(IN_W), .CHECK_MASK(10'h3FE)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b),
        .step_count(cnt_b), .chain_err(cerr_b), .err_step(estep_b),
        .frame_err(ferr_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for tiny86: output regs are a simple function of the step
    function automatic logic [REGS_W-1:0] fake_exec(input logic [STEP_W-1:0] s);
        logic [REGS_W-1:0] r;
        r = s[STEP_REGS_HI:STEP_REGS_LO];
        for (int i = 0; i < NUM_REGS; i++)
            r[i*32 +: 32] = r[i*32 +: 32] ^ (s[559:528] + 32'(i));
        return r;
    endfunction

    assign if_a.exec_regs = fake_exec(if_a.step);
    assign if_b.exec_regs = fake_exec(if_b.step);

    logic [STEP_W-1:0] trace [$];
    logic [STEP_W-1:0] obs_a [$];
    logic [STEP_W-1:0] obs_b [$];

    int n_checks = 0;
    int n_fail   = 0;

    // Record every presented step; cleared while reset is held
    always @(negedge clk) begin
        if (!rst_n) begin
            obs_a.delete();
            obs_b.delete();
        end else begin
            if (if_a.step_valid) obs_a.push_back(if_a.step);
            if (if_b.step_valid) obs_b.push_back(if_b.step);
        end
    end

    task automatic check_eq(input string tag, input logic [STEP_W-1:0] obs, input logic [STEP_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [IN_W-1:0] d, input logic v, input logic l);
        if_a.in_data = d; if_a.in_valid = v; if_a.in_last = l;
        if_b.in_data = d; if_b.in_valid = v; if_b.in_last = l;
    endtask

    function automatic logic [STEP_W-1:0] rand_step();
        logic [STEP_W-1:0] s;
        for (int b = 0; b < BEATS; b++) s[b*16 +: 16] = 16'($urandom);
        return s;
    endfunction

    task automatic build_chain(input int n);
        logic [STEP_W-1:0] s;
        trace.delete();
        for (int k = 0; k < n; k++) begin
            s = rand_step();
            if (k > 0) s[STEP_REGS_HI:STEP_REGS_LO] = fake_exec(trace[k-1]);
            trace.push_back(s);
        end
    endtask

    task automatic corrupt(input int k, input int r, input logic [31:0] x);
        logic [STEP_W-1:0] s;
        s = trace[k];
        s[STEP_REGS_LO + r*32 +: 32] = s[STEP_REGS_LO + r*32 +: 32] ^ x;
        trace[k] = s;
    endtask

    // Trace-level expectation: first presented step (k>=1) whose enabled
    // input registers differ from the previous step's tiny86 outputs.
    task automatic model(input logic [9:0] mask, input int n_done,
                         output logic ce, output logic [31:0] es);
        logic [REGS_W-1:0] prev, cur;
        ce = 1'b0; es = 32'd0;
        for (int k = 1; k < n_done; k++) begin
            prev = fake_exec(trace[k-1]);
            cur  = trace[k][STEP_REGS_HI:STEP_REGS_LO];
            for (int r = 0; r < NUM_REGS; r++) begin
                if (mask[r] && cur[r*32 +: 32] != prev[r*32 +: 32] && !ce) begin
                    ce = 1'b1;
                    es = 32'(k);
                end
            end
        end
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_count",  cnt_a,           0);
        check_eq("rst_cerr",   cerr_a,          0);
        check_eq("rst_estep",  estep_a,         0);
        check_eq("rst_ferr",   ferr_a,          0);
        check_eq("rst_done",   done_a | done_b, 0);
        check_eq("rst_sv",     if_a.step_valid, 0);
        check_eq("rst_step",   if_a.step,       0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready",  if_a.in_ready,   1);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic send_beat(input logic [IN_W-1:0] d, input logic l, output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        drive(d, 1'b1, l);
        while (!if_a.in_ready) begin
            @(negedge clk);
            w++;
            if (w > 50) begin
                check_eq("hs_timeout", if_a.in_ready, 1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) @(posedge clk);
        @(negedge clk);
        drive('0, 1'b0, 1'b0);
    endtask

    task automatic run_trace(input int gap_pct, input int bad_beat, input int prefix_beats);
        int                n, n_done, g, gidx, w;
        bit                ok, stop;
        logic              l;
        logic [STEP_W-1:0] s;
        logic              ce;
        logic [31:0]       es;

        do_reset();
        if (prefix_beats > 0) begin
            for (int i = 0; i < prefix_beats; i++) send_beat(16'($urandom), 1'b0, ok);
            do_reset();
        end

        n      = trace.size();
        n_done = 0;
        stop   = 1'b0;
        for (int k = 0; k < n && !stop; k++) begin
            s = trace[k];
            for (int b = 0; b < BEATS; b++) begin
                g = (int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(1, 4)) : 0;
                repeat (g) @(negedge clk);
                gidx = k * BEATS + b;
                l    = (gidx == bad_beat) || (k == n - 1 && b == BEATS - 1);
                send_beat(s[STEP_W - 1 - IN_W*b -: IN_W], l, ok);
                if (!ok) begin stop = 1'b1; break; end
                if (gidx == bad_beat) begin
                    check_eq("fe_no_strobe", if_a.step_valid, 0);
                    stop = 1'b1;
                    break;
                end
                if (b == BEATS - 1) begin
                    n_done++;
                    check_eq("latency_sv",  if_a.step_valid, 1);
                    check_eq("exec_ready",  if_a.in_ready,   0);
                    if (k != n - 1) begin
                        @(negedge clk);
                        check_eq("refill_ready", if_a.in_ready, 1);
                    end
                end
            end
        end

        w = 0;
        while (!done_a && w < 20) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);

        check_eq("done_a",     done_a,          1);
        check_eq("done_ready", if_a.in_ready,   0);
        check_eq("done_sv",    if_a.step_valid, 0);
        check_eq("ferr_a",     ferr_a,          (bad_beat >= 0) ? 1 : 0);
        check_eq("count_a",    cnt_a,           n_done);
        check_eq("strobes_a",  obs_a.size(),    n_done);
        for (int i = 0; i < obs_a.size() && i < n_done; i++)
            check_eq("step_a", obs_a[i], trace[i]);
        model(10'h3FF, n_done, ce, es);
        check_eq("cerr_a",  cerr_a,  ce);
        check_eq("estep_a", estep_a, es);

        check_eq("done_b",    done_b,       1);
        check_eq("ferr_b",    ferr_b,       (bad_beat >= 0) ? 1 : 0);
        check_eq("count_b",   cnt_b,        n_done);
        check_eq("strobes_b", obs_b.size(), n_done);
        for (int i = 0; i < obs_b.size() && i < n_done; i++)
            check_eq("step_b", obs_b[i], trace[i]);
        model(10'h3FE, n_done, ce, es);
        check_eq("cerr_b",  cerr_b,  ce);
        check_eq("estep_b", estep_b, es);
    endtask

    initial begin
        int n, bad, pre;
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);

        // Single step
        build_chain(1);
        run_trace(0, -1, 0);
        // Two continuous steps
        build_chain(2);
        run_trace(0, -1, 0);
        // eax break at step 2, later break at step 3 must not move err_step
        build_chain(4);
        corrupt(2, REG_EAX, 32'h1);
        corrupt(3, REG_ESI, 32'h10);
        run_trace(0, -1, 0);
        // eflags-only break: only the full-mask instance flags it
        build_chain(2);
        corrupt(1, REG_EFLAGS, 32'h4);
        run_trace(0, -1, 0);
        // in_last on beat 10 of the first step
        build_chain(1);
        run_trace(0, 9, 0);
        // Reset mid-fill, then a full step, without and with gaps
        build_chain(1);
        run_trace(0, -1, 20);
        run_trace(40, -1, 20);

        // Randomised traces
        for (int it = 0; it < 24; it++) begin
            n = int'($urandom_range(1, 5));
            build_chain(n);
            for (int k = 1; k < n; k++)
                if ($urandom_range(99) < 30)
                    corrupt(k, int'($urandom_range(0, NUM_REGS - 1)), $urandom | 32'h1);
            bad = -1;
            if ($urandom_range(99) < 20) begin
                bad = int'($urandom_range(0, n * BEATS - 1));
                if (bad % BEATS == BEATS - 1) bad = bad - 1;
            end
            pre = ($urandom_range(99) < 20) ? int'($urandom_range(1, BEATS - 1)) : 0;
            run_trace(int'($urandom_range(0, 50)), bad, pre);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_trace_step_sequencer
`default_nettype wire
